div_result_buffer: RTL
======================

// Module: div_result_buffer
// PURPOSE
//  Output stage directly downstream of the pipelined divider. Captures each
//  {quotient, div_by_zero} result on the divider's data_valid strobe into a
//  DEPTH-entry FIFO and presents it on a valid/ready interface. Also tracks
//  divides in flight, so the issuing logic only asserts the divider's start
//  when a result slot is guaranteed. The divider cannot stall.
// PARAMETERS
//  BITS       8  quotient width; matches the divider's BITS
//  DEPTH      4  FIFO entries; power of two, >=2
//  ADDR_BITS  2  log2(DEPTH); count/in-flight counters are ADDR_BITS+1 wide
// PORTS
//  clk              in   1          rising-edge clock, sole clock domain
//  reset            in   1          synchronous, active-high reset
//  issue            in   1          divider start pulse (one divide issued)
//  issue_ok         out  1          1 = a new issue is permitted this cycle
//  in_valid         in   1          divider data_valid strobe
//  in_quotient      in   BITS       divider quotient
//  in_div_by_zero   in   1          divider div_by_zero flag
//  out_valid        out  1          head entry available
//  out_ready        in   1          consumer accepts head entry
//  out_quotient     out  BITS       head quotient
//  out_div_by_zero  out  1          head div_by_zero flag
//  count            out  ADDR_BITS+1  entries stored (0..DEPTH)
//  full             out  1          count == DEPTH
//  overflow         out  1          sticky: a result was dropped
// BEHAVIOUR
//  - Reset (sync, wins over all inputs): wr/rd pointers=0, count=0,
//    in_flight=0, overflow=0; out_valid=0, full=0, issue_ok=1;
//    out_quotient/out_div_by_zero=0 (storage cleared).
//  - pop = out_valid & out_ready. push = in_valid & (!full | pop).
//  - Push: writes {in_quotient,in_div_by_zero} at wr_ptr; wr_ptr wraps mod DEPTH.
//  - Pop: rd_ptr++ mod DEPTH. count += push - pop; push and pop together leave
//    count unchanged, including when full.
//  - Outputs come from registers (entry at rd_ptr): first-word fall-through,
//    latency 1. A result pushed in cycle N is on out_* with out_valid=1 in N+1.
//    A same-cycle pop into an empty FIFO is impossible (out_valid=0).
//  - out_* hold steady while out_valid & !out_ready.
//  - Overflow: in_valid & full & !pop -> result dropped, overflow=1 next
//    cycle and held until reset; FIFO contents unchanged.
//  - in_flight: +1 on issue&issue_ok, -1 on in_valid; both -> unchanged.
//    Saturates at 0: in_valid with in_flight==0 still pushes, no error.
//    An issue while issue_ok==0 is ignored by the counter (protocol error).
//  - issue_ok = (count + in_flight) < DEPTH, registered-state only (no
//    combinational path from issue/in_valid/out_ready).
//  - Reset mid-operation: results still in the divider pipeline arrive after
//    reset and are pushed normally. Reset the divider in the same cycle.
//  - Arithmetic: count, in_flight and their sum are ADDR_BITS+1 bits; the sum
//    never exceeds DEPTH under legal use.
// TESTING
//  1 Reset: assert reset 2 cycles with in_valid=1 -> count=0, out_valid=0,
//    issue_ok=1, overflow=0 after release.
//  2 Single push: in_valid=1, q=8'h2A, dbz=0 in cycle N -> out_valid=1,
//    out_quotient=8'h2A in N+1; out_ready=1 -> count back to 0 in N+2.
//  3 Fill/order: push 8'h01..8'h04 with out_ready=0 -> full=1, issue_ok=0;
//    drain -> 01,02,03,04 in order; 5th push while full sets overflow=1,
//    contents unchanged.
//  4 Full push+pop: full, in_valid=1 (q=8'h55) & out_ready=1 same cycle ->
//    count stays 4, 8'h55 is the last entry drained.
//  5 Credit: 4 issue pulses, no in_valid -> issue_ok=0 after the 4th;
//    one in_valid then one pop -> issue_ok=1 again.
//  6 div_by_zero passthrough: push q=8'hFF, dbz=1 -> out_div_by_zero=1 with
//    out_quotient=8'hFF.

Source files
------------

// File: rtl/div_result_buffer.sv
// Result FIFO behind the pipelined divider: captures {quotient, div_by_zero}
// on data_valid, presents it on valid/ready, and grants issue credits.
module div_result_buffer #(
    parameter int BITS      = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue,
    output logic                 issue_ok,
    input  logic                 in_valid,
    input  logic [BITS-1:0]      in_quotient,
    input  logic                 in_div_by_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BITS-1:0]      out_quotient,
    output logic                 out_div_by_zero,
    output logic [ADDR_BITS:0]   count,
    output logic                 full,
    output logic                 overflow
);

    localparam int                 ENTRY_W = BITS + 1;
    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS + 1)'(DEPTH);

    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count_q;
    logic [ADDR_BITS:0]   in_flight;
    logic [ADDR_BITS:0]   occupancy;
    logic                 push;
    logic                 pop;
    logic                 credit_take;

    // Status and head data are pure functions of registered state, so there
    // is no combinational path from issue/in_valid/out_ready to any output.
    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign full      = (count_q == DEPTH_C);
    assign occupancy = count_q + in_flight;
    assign issue_ok  = (occupancy < DEPTH_C);

    assign {out_quotient, out_div_by_zero} = mem[rd_ptr];

    assign pop         = out_valid & out_ready;
    assign push        = in_valid & (~full | pop);
    assign credit_take = issue & issue_ok;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            in_flight <= '0;
            overflow  <= 1'b0;
            // NOTE: storage is cleared on reset because out_quotient and
            // out_div_by_zero read it directly and must be 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // When full, a simultaneous pop reads the head before this write
            // overwrites the same slot, so push+pop at full is safe.
            if (push) begin
                mem[wr_ptr] <= {in_quotient, in_div_by_zero};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (in_valid & full & ~pop) begin
                overflow <= 1'b1;
            end

            // A result arriving with nothing in flight is still accepted;
            // the credit counter simply saturates at zero.
            if (credit_take & ~in_valid) begin
                in_flight <= in_flight + 1'b1;
            end else if (~credit_take & in_valid & (in_flight != '0)) begin
                in_flight <= in_flight - 1'b1;
            end
        end
    end

endmodule
